// File: rtl/fft_pkg.sv
// fft_pkg: complex sample type, Q1.15 constants and the HALF-bit reduction helpers.
// Define IBFLY_SAT_EN to make the reductions saturate. Leave it undefined to get two's-complement wrap.
package fft_pkg;
  localparam int HALF = 16;
  localparam int QF = HALF - 1;
  localparam logic signed [33:0] RND = 34'sd1 <<< (QF - 1);
  typedef struct packed {
    logic signed [HALF-1:0] re, im;
  } cplx_t;
  function automatic logic signed [HALF-1:0] sat_or_wrap(input logic signed [33:0] v);
`ifdef IBFLY_SAT_EN
    return (v > ((34'sd1 <<< QF) - 34'sd1)) ? HALF'((34'sd1 <<< QF) - 34'sd1) :
           (v < -(34'sd1 <<< QF)) ? HALF'(-(34'sd1 <<< QF)) : HALF'(v);
`else
    return HALF'(v);
`endif
  endfunction
  // Rounded halving, (v+1)>>>1, followed by the reduction back to HALF bits
  function automatic logic signed [HALF-1:0] half_rnd(input logic signed [33:0] v);
    return sat_or_wrap((v + 34'sd1) >>> 1);
  endfunction
endpackage

// File: rtl/cmul_conj_rnd.sv
// cmul_conj_rnd: registered d*conj(w) product stage with a combinational Q1.15 round/reduce on its output.
module cmul_conj_rnd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] d,
  input  logic [31:0] w,
  output logic [31:0] b
);
  import fft_pkg::*;
  cplx_t dc, wc;
  logic signed [32:0] br_f, bi_f;
  assign dc = d;
  assign wc = w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_f <= '0;
      bi_f <= '0;
    end else if (en) begin
      br_f <= 33'(32'(dc.re) * 32'(wc.re)) + 33'(32'(dc.im) * 32'(wc.im));
      bi_f <= 33'(32'(dc.im) * 32'(wc.re)) - 33'(32'(dc.re) * 32'(wc.im));
    end
  end
  assign b = {sat_or_wrap((34'(br_f) + RND) >>> QF), sat_or_wrap((34'(bi_f) + RND) >>> QF)};
endmodule

// File: rtl/ibutterfly_pipe.sv
// ibutterfly_pipe: 3-stage radix-2 inverse butterfly, A=(X0+X1)/2 and B=((X0-X1)/2)*conj(W), valid/ready on both sides.
// The IBFLY_SAT_EN macro selects saturating rather than wrapping reductions. Timing is identical in both builds.
module ibutterfly_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);
  import fft_pkg::*;
  logic v1, v2, v3, adv;
  cplx_t xa, xb, a_n, dh_n, a1, a2, dh1, bq;
  logic [WIDTH-1:0] w1;
  // The whole pipe moves in lockstep: it stalls only when the output register is full and not taken
  assign adv = !v3 || out_ready;
  assign in_ready = adv;
  assign out_valid = v3;
  assign xa = x0;
  assign xb = x1;
  assign a_n = {half_rnd(34'(xa.re) + 34'(xb.re)), half_rnd(34'(xa.im) + 34'(xb.im))};
  assign dh_n = {half_rnd(34'(xa.re) - 34'(xb.re)), half_rnd(34'(xa.im) - 34'(xb.im))};
  cmul_conj_rnd u_cmul (
    .clk(clk),
    .rst_n(rst_n),
    .en(adv),
    .d(dh1),
    .w(w1),
    .b(bq)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
      dh1 <= '0;
      w1 <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      a1 <= a_n;
      dh1 <= dh_n;
      w1 <= w;
      a2 <= a1;
      a_out <= a2;
      b_out <= bq;
    end
  end
endmodule

// File: tb/tb_ibutterfly_pipe.sv
// tb_ibutterfly_pipe: table vectors, handshake corner sequences and random traffic against an arithmetic reference model.
module tb_ibutterfly_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] x0 = '0, x1 = '0, w = '0;
  logic [31:0] a_out, b_out;
  int checks = 0;
  int errors = 0;
  int outs = 0;
  bit acc;
  logic [63:0] sb[$];
  typedef struct {
    logic [31:0] x0, x1, w, ea, eb;
  } vec_t;
  vec_t tv[4];
  logic [31:0] bx[5][3];

  ibutterfly_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic longint fdiv(longint n, longint d);
    longint r;
    r = n % d;
    if (r < 0) r += d;
    return (n - r) / d;
  endfunction

  function automatic longint red(longint v);
    longint m;
`ifdef IBFLY_SAT_EN
    m = v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
`else
    m = v & 64'hFFFF;
    if (m >= 32768) m -= 65536;
`endif
    return m;
  endfunction

  function automatic longint sx(logic [15:0] h);
    return longint'($signed(h));
  endfunction

  // A = (X0+X1)/2 and B = ((X0-X1)/2)*conj(W), each halving and product rounded to nearest
  function automatic logic [63:0] model(logic [31:0] p, logic [31:0] q, logic [31:0] t);
    longint ar, ai, dr, di, wr, wi, br, bi;
    ar = red(fdiv(sx(p[31:16]) + sx(q[31:16]) + 1, 2));
    ai = red(fdiv(sx(p[15:0]) + sx(q[15:0]) + 1, 2));
    dr = red(fdiv(sx(p[31:16]) - sx(q[31:16]) + 1, 2));
    di = red(fdiv(sx(p[15:0]) - sx(q[15:0]) + 1, 2));
    wr = sx(t[31:16]);
    wi = sx(t[15:0]);
    br = red(fdiv(dr * wr + di * wi + 16384, 32768));
    bi = red(fdiv(di * wr - dr * wi + 16384, 32768));
    return {ar[15:0], ai[15:0], br[15:0], bi[15:0]};
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, then score whatever transfers at the next rising edge
  task automatic step(input logic iv, input logic ordy, input logic [31:0] p, input logic [31:0] q, input logic [31:0] t);
    logic [63:0] e;
    @(negedge clk);
    in_valid = iv;
    out_ready = ordy;
    x0 = p;
    x1 = q;
    w = t;
    #1;
    if (out_valid && out_ready) begin
      outs++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h_%h expected none", a_out, b_out);
      end else begin
        e = sb.pop_front();
        chk("a_out", {32'h0, a_out}, {32'h0, e[63:32]});
        chk("b_out", {32'h0, b_out}, {32'h0, e[31:0]});
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(model(p, q, t));
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, 1'b1, '0, '0, '0);
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int lat, n, seen, base;
    logic [31:0] held;
    logic [6:0] pat;
    tv[0] = '{32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 32'h3000_0000, 32'h1000_0000};
    tv[1] = '{32'h4000_0000, 32'h2000_0000, 32'h0000_8001, 32'h3000_0000, 32'h0000_1000};
`ifdef IBFLY_SAT_EN
    tv[2] = '{32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h0000_0000, 32'h7FFE_0000};
`else
    tv[2] = '{32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h0000_0000, 32'h8001_0000};
`endif
    tv[3] = '{32'h0000_4000, 32'h0000_C000, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_4000};
    #2;
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_a_out", {32'h0, a_out}, 64'd0);
    chk("rst_b_out", {32'h0, b_out}, 64'd0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, tv[i].x0, tv[i].x1, tv[i].w);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        step(1'b0, 1'b1, '0, '0, '0);
        if (out_valid) begin
          lat = k;
          break;
        end
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_a", i), {32'h0, a_out}, {32'h0, tv[i].ea});
      chk($sformatf("vec%0d_b", i), {32'h0, b_out}, {32'h0, tv[i].eb});
    end
    drain();

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 3; j++) bx[i][j] = $urandom;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, bx[n][0], bx[n][1], bx[n][2]);
      if (acc) n++;
    end
    chk("bp_accepts", 64'(n), 64'd3);
    chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'h0, out_valid}, 64'd1);
    held = a_out;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, bx[n][0], bx[n][1], bx[n][2]);
      chk("bp_hold", {32'h0, a_out}, {32'h0, held});
    end
    base = outs;
    for (int k = 0; k < 5; k++) begin
      step(n < 5, 1'b1, bx[n < 5 ? n : 4][0], bx[n < 5 ? n : 4][1], bx[n < 5 ? n : 4][2]);
      if (k == 0) chk("bp_release_in_ready", {63'h0, in_ready}, 64'd1);
      if (acc) n++;
    end
    chk("bp_outputs_5_cycles", 64'(outs - base), 64'd5);
    chk("bp_scoreboard_empty", 64'(sb.size()), 64'd0);
    drain();

    pat = '0;
    step(1'b1, 1'b1, $urandom, $urandom, $urandom);
    pat = {pat[5:0], out_valid};
    step(1'b0, 1'b1, '0, '0, '0);
    pat = {pat[5:0], out_valid};
    step(1'b1, 1'b1, $urandom, $urandom, $urandom);
    pat = {pat[5:0], out_valid};
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, '0, '0, '0);
      pat = {pat[5:0], out_valid};
    end
    chk("bubble_pattern", {57'h0, pat}, {57'h0, 7'b0001010});
    drain();

    n = 0;
    for (int k = 0; k < 6 && n < 3; k++) begin
      step(1'b1, 1'b0, $urandom | 32'h0100_0100, $urandom, 32'h7FFF_0000);
      if (acc) n++;
    end
    chk("rst_mid_inflight", 64'(n), 64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_mid_a_out", {32'h0, a_out}, 64'd0);
    chk("rst_mid_b_out", {32'h0, b_out}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, '0, '0, '0);
      seen += int'(out_valid);
    end
    chk("rst_no_stale", 64'(seen), 64'd0);
    step(1'b1, 1'b1, $urandom, $urandom, $urandom);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, '0, '0, '0);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("rst_after_latency", 64'(lat), 64'd3);
    drain();

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
